// File: rtl/evict_wb_drain.sv
// Write-back eviction buffer drain: line FIFO with coalescing, newest-first lookup
// and a one-line-at-a-time pmem writer.
//
// state | meaning
// IDLE  | no request outstanding; latches head line when buffer is non-empty
// WRITE | pmem_write held with latched head line until pmem_resp
module evict_wb_drain #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   evict_write,
    input  logic [15:0]            evict_address,
    input  logic [127:0]           evict_wdata,
    output logic                   evict_ready,
    input  logic [15:0]            lookup_address,
    output logic                   lookup_hit,
    output logic [127:0]           lookup_rdata,
    output logic                   pmem_write,
    output logic [15:0]            pmem_address,
    output logic [127:0]           pmem_wdata,
    input  logic                   pmem_resp,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t          state, next_state;
    logic [DEPTH-1:0] valid;
    logic [11:0]     tags [DEPTH];
    logic [127:0]    data [DEPTH];
    logic [AW-1:0]   head, tail;
    logic            enq, alloc, pop, load;
    logic            co_hit;
    logic [AW-1:0]   co_idx;
    logic            unused_bits;

    assign unused_bits = ^{evict_address[3:0], lookup_address[3:0]};

    assign evict_ready = (count < CW'(DEPTH));
    assign empty       = (count == '0);
    assign enq         = evict_write && evict_ready;
    assign alloc       = enq && !co_hit;

    // Only one non-head copy of a tag can exist, so the first match is the match.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && tags[i] == evict_address[15:4] && AW'(i) != head) begin
                co_hit = 1'b1;
                co_idx = AW'(i);
            end
        end
    end

    // Walk from head towards tail so the newest matching copy wins.
    always_comb begin
        logic [AW-1:0] idx;
        idx          = '0;
        lookup_hit   = 1'b0;
        lookup_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (valid[idx] && tags[idx] == lookup_address[15:4]) begin
                lookup_hit   = 1'b1;
                lookup_rdata = data[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (alloc) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            count <= count + CW'(alloc) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            tags[tail] <= evict_address[15:4];
            data[tail] <= evict_wdata;
        end else if (enq) begin
            data[co_idx] <= evict_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else if (load) begin
            pmem_address <= {tags[head], 4'b0000};
            pmem_wdata   <= data[head];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        pmem_write = 1'b0;
        pop        = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    load       = 1'b1;
                    next_state = WRITE;
                end
            end
            WRITE: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    pop        = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: doc/evict_wb_drain.md
# evict_wb_drain

Drain side of the L2 write-back eviction buffer: a DEPTH-entry line-aligned FIFO that accepts dirty 128-bit victim lines from the cache controller and writes them to physical memory in arrival order, one at a time, over the pmem write handshake. Entries still pending are visible on a lookup port, so cache misses can be served from the buffer instead of stale memory. Sits between the cache's eviction path and the physical-memory arbiter.

## Interface
Parameters:
- DEPTH, 4, number of line entries; power of two, ≥2.

Ports:
- clk  in  1  single clock, all state rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- evict_write  in  1  enqueue request; sampled only when evict_ready=1.
- evict_address  in  16  victim line address (lc3b_word); bits [3:0] ignored.
- evict_wdata  in  128  victim line data (lc3b_data).
- evict_ready  out  1  buffer can accept an eviction this cycle.
- lookup_address  in  16  probe address; bits [3:0] ignored.
- lookup_hit  out  1  probe matches a valid entry (combinational).
- lookup_rdata  out  128  data of matching entry; 0 when lookup_hit=0.
- pmem_write  out  1  write request to physical memory.
- pmem_address  out  16  line address of request, bits [3:0] = 0.
- pmem_wdata  out  128  line data of request.
- pmem_resp  in  1  memory completion; one-cycle pulse.
- empty  out  1  no valid entries.
- count  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Storage per entry: valid, tag = address[15:4], 128-bit data. Head/tail pointers wrap modulo DEPTH.
- Enqueue (evict_write & evict_ready): if tag matches a valid entry other than head, overwrite that entry's data in place (coalesce; count unchanged). Otherwise write at tail, set valid, tail+1, count+1. Head entry is never coalesced into — a match with head allocates a new entry.
- evict_ready = (count < DEPTH). Computed from current count only; a same-cycle pop does not make a full buffer ready.
- Lookup: compare lookup_address[15:4] with all valid tags. Multiple matches (head plus a newer copy) → return the newest (farthest from head).
- Drain FSM:
  - IDLE: pmem_write=0. If count≠0 → WRITE; pmem_address/pmem_wdata registers load from head entry ({tag,4'b0}, data).
  - WRITE: pmem_write=1; address/data held stable. On pmem_resp: clear head valid, head+1, count−1, → IDLE.
  - One idle cycle between consecutive writes.
- Simultaneous enqueue (new entry) and pop: count unchanged, both pointers advance.
- pmem_resp in IDLE: ignored.

## Timing
- Reset (async assert): all valid=0, head=tail=0, count=0, state IDLE, pmem_write=0, pmem_address=0, pmem_wdata=0; hence evict_ready=1, empty=1, lookup_hit=0, lookup_rdata=0. Reset mid-WRITE drops pmem_write immediately; in-flight and queued lines are discarded.
- Enqueue visible to lookup the cycle after the accepting edge.
- Empty buffer, enqueue at edge N → count=1 after N; pmem_write rises after edge N+1.
- pmem_resp at edge M → pmem_write low, count−1 after M; next write (if any) asserts after M+1.
- lookup_hit/lookup_rdata purely combinational from registered state and lookup_address; no dependence on evict_* inputs in the same cycle.
- Popped entry is no longer hit-visible after the pmem_resp edge.

## Test plan
- Reset then single eviction: address 0x1234, data 0xA5…A5 → pmem_write rises two edges later with pmem_address=0x1230, data 0xA5…A5; pmem_resp after 3 cycles → empty=1, count=0, pmem_write=0.
- Fill: four evictions 0x0010,0x0020,0x0030,0x0040 with pmem_resp held 0 → count=4, evict_ready=0; fifth request ignored; responses drain in order 0x0010..0x0040, one idle cycle between writes.
- Coalesce: queue 0x0100 (head, in flight) and 0x0200; evict 0x0208 data D2' → count stays 2, drained 0x0200 carries D2'; evict 0x0104 → count 3 (new entry, head untouched).
- Lookup newest: head 0x0300 data X in WRITE, re-evict 0x0300 data Y → lookup 0x0305 returns Y; lookup 0x0400 → lookup_hit=0, rdata=0.
- Full with simultaneous pop: count=4, pmem_resp and evict_write same cycle → eviction not accepted, count=3, evict_ready=1 next cycle.
- Reset mid-WRITE: assert reset_n=0 while pmem_write=1 → pmem_write=0 without clock edge, count=0, later pmem_resp ignored.
